// File: rtl/mosfet_deadtime_gen_pkg.sv
// Shared types and constants for the MOSFET dead-time generator.
package mosfet_deadtime_gen_pkg;

  // Per-leg state. FAULT is tracked as a separate sticky flag.
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2,
    ST_DEAD = 2'd3
  } leg_state_t;

  // Leg request decoded from the {hi, lo} command bits.
  typedef enum logic [1:0] {
    TGT_NONE    = 2'b00,
    TGT_LO      = 2'b01,
    TGT_HI      = 2'b10,
    TGT_ILLEGAL = 2'b11
  } leg_target_t;

  // Bit positions in the command word and gate vector.
  localparam int LEG_A_HI = 0;
  localparam int LEG_B_HI = 1;
  localparam int LEG_A_LO = 2;
  localparam int LEG_B_LO = 3;

  function automatic leg_target_t decode_target(input logic hi, input logic lo);
    return leg_target_t'({hi, lo});
  endfunction

endpackage

// File: rtl/mosfet_deadtime_gen_leg.sv
// One half-bridge leg: dead-time insertion, shoot-through blocking and
// sticky fault on a simultaneous hi+lo request.
module deadtime_leg
  import mosfet_deadtime_gen_pkg::*;
#(
  parameter int DEADTIME = 25,
  parameter int CNT_W    = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       hi_req,
  input  logic       lo_req,
  output logic       hi_gate,
  output logic       lo_gate,
  output logic       dead,
  output logic       fault,
  output leg_state_t state
);

  // Loading DEADTIME-1 and switching on the edge the counter reads zero
  // gives exactly DEADTIME cycles with both gates low.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEADTIME - 1);

  leg_state_t       state_q, state_d;
  leg_state_t       pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  leg_target_t      tgt;
  leg_state_t       tgt_state;

  assign tgt       = decode_target(hi_req, lo_req);
  assign tgt_state = (tgt == TGT_HI) ? ST_HI : ST_LO;

  // Next-state logic: fault latch, then illegal request, then enable, then FSM.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    fault_d   = fault_q;
    if (fault_q) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else if (tgt == TGT_ILLEGAL) begin
      fault_d = 1'b1;
      state_d = ST_OFF;
      cnt_d   = '0;
    end else if (!enable) begin
      state_d = ST_OFF;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (tgt != TGT_NONE) begin
            state_d   = ST_DEAD;
            cnt_d     = CNT_LOAD;
            pending_d = tgt_state;
          end
        end
        ST_HI: begin
          if (tgt == TGT_LO) begin
            state_d   = ST_DEAD;
            cnt_d     = CNT_LOAD;
            pending_d = ST_LO;
          end else if (tgt == TGT_NONE) begin
            state_d = ST_OFF;
          end
        end
        ST_LO: begin
          if (tgt == TGT_HI) begin
            state_d   = ST_DEAD;
            cnt_d     = CNT_LOAD;
            pending_d = ST_HI;
          end else if (tgt == TGT_NONE) begin
            state_d = ST_OFF;
          end
        end
        ST_DEAD: begin
          if (tgt == TGT_NONE) begin
            state_d = ST_OFF;
            cnt_d   = '0;
          end else begin
            // Pending side tracks the request; the count is never restarted.
            pending_d = tgt_state;
            if (cnt_q == '0) state_d = pending_d;
            else             cnt_d   = cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  // State register; gate/dead outputs are flopped from the next-state decode.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_OFF;
      pending_q <= ST_OFF;
      cnt_q     <= '0;
      fault_q   <= 1'b0;
      hi_gate   <= 1'b0;
      lo_gate   <= 1'b0;
      dead      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      fault_q   <= fault_d;
      hi_gate   <= (state_d == ST_HI);
      lo_gate   <= (state_d == ST_LO);
      dead      <= (state_d == ST_DEAD);
    end
  end

  assign fault = fault_q;
  assign state = state_q;

endmodule

// File: rtl/mosfet_deadtime_gen.sv
// Full-bridge gate driver: registers the controller command word and drives
// two independent dead-time legs.
module mosfet_deadtime_gen
  import mosfet_deadtime_gen_pkg::*;
#(
  parameter int DEADTIME = 25,
  parameter int CNT_W    = 8
) (
  input  logic       i_clock,
  input  logic       i_RESET,
  input  logic       i_enable,
  input  logic [3:0] i_MOSFET,
  output logic [3:0] o_gate,
  output logic [1:0] o_dead,
  output logic [1:0] o_fault,
  output logic [7:0] o_debug
);

  logic [3:0] cmd_q;
  logic [1:0] hi_gate;
  logic [1:0] lo_gate;
  leg_state_t state_a;
  leg_state_t state_b;

  // Command input register (stage boundary between controller and legs).
  always_ff @(posedge i_clock or negedge i_RESET) begin
    if (!i_RESET) cmd_q <= '0;
    else          cmd_q <= i_MOSFET;
  end

  deadtime_leg #(.DEADTIME(DEADTIME), .CNT_W(CNT_W)) u_leg_a (
    .clock   (i_clock),
    .reset_n (i_RESET),
    .enable  (i_enable),
    .hi_req  (cmd_q[LEG_A_HI]),
    .lo_req  (cmd_q[LEG_A_LO]),
    .hi_gate (hi_gate[0]),
    .lo_gate (lo_gate[0]),
    .dead    (o_dead[0]),
    .fault   (o_fault[0]),
    .state   (state_a)
  );

  deadtime_leg #(.DEADTIME(DEADTIME), .CNT_W(CNT_W)) u_leg_b (
    .clock   (i_clock),
    .reset_n (i_RESET),
    .enable  (i_enable),
    .hi_req  (cmd_q[LEG_B_HI]),
    .lo_req  (cmd_q[LEG_B_LO]),
    .hi_gate (hi_gate[1]),
    .lo_gate (lo_gate[1]),
    .dead    (o_dead[1]),
    .fault   (o_fault[1]),
    .state   (state_b)
  );

  assign o_gate[LEG_A_HI] = hi_gate[0];
  assign o_gate[LEG_B_HI] = hi_gate[1];
  assign o_gate[LEG_A_LO] = lo_gate[0];
  assign o_gate[LEG_B_LO] = lo_gate[1];

  assign o_debug = {state_b, state_a, o_dead, o_fault};

endmodule
